// File: rtl/rf_pkg.sv
// Shared sizing constants for the ALU register file and its forwarding muxes.
package rf_pkg;

  localparam int DATA_W = 8;
  localparam int NREG   = 4;
  localparam int AW     = $clog2(NREG);

  localparam logic [AW-1:0] R_ZERO = '0;

endpackage

// File: rtl/rf_fwd_mux.sv
// Forwarding mux for one read port: resolves the freshest value of a register
// from the live write, the writeback stage, or the array.
module rf_fwd_mux
  import rf_pkg::*;
(
  input  logic [AW-1:0]     addr,
  input  logic              RegWrite,
  input  logic [AW-1:0]     WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] fwd_data
);

  // Youngest source first: the live write beats the writeback stage,
  // which in turn beats the array.
  always_comb begin
    fwd_data = arr_data;
    if (addr == R_ZERO) begin
      fwd_data = '0;
    end else if (RegWrite && (WriteReg == addr)) begin
      fwd_data = WriteData;
    end else if (wb_valid && (wb_addr == addr)) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// ALU register file: two registered read ports, a display port, and a write port
// that commits through a one-entry writeback stage with full forwarding.
module register_file
  import rf_pkg::*;
(
  input  logic              Clk,
  input  logic              Clear,
  input  logic              RegWrite,
  input  logic [AW-1:0]     WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [AW-1:0]     ReadReg1,
  input  logic [AW-1:0]     ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [AW-1:0]     DispReg,
  output logic [DATA_W-1:0] DispData,
  output logic              WB_Pending
);

  logic [DATA_W-1:0] regs [NREG];

  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              write_ok;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  // Writes aimed at the hardwired zero register never enter the pipeline.
  assign write_ok = RegWrite && (WriteReg != R_ZERO);

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= write_ok;
      if (write_ok) begin
        wb_addr <= WriteReg;
        wb_data <= WriteData;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

  rf_fwd_mux u_fwd1 (
    .addr      (ReadReg1),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .arr_data  (regs[ReadReg1]),
    .fwd_data  (fwd1)
  );

  rf_fwd_mux u_fwd2 (
    .addr      (ReadReg2),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .arr_data  (regs[ReadReg2]),
    .fwd_data  (fwd2)
  );

  rf_fwd_mux u_fwd_disp (
    .addr      (DispReg),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .arr_data  (regs[DispReg]),
    .fwd_data  (DispData)
  );

  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      ReadData1 <= '0;
      ReadData2 <= '0;
    end else begin
      ReadData1 <= fwd1;
      ReadData2 <= fwd2;
    end
  end

  assign WB_Pending = wb_valid;

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an architectural
// model in which every accepted write is visible immediately.
module tb_register_file;
  import rf_pkg::*;

  logic              Clk;
  logic              Clear;
  logic              RegWrite;
  logic [AW-1:0]     WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [AW-1:0]     ReadReg1;
  logic [AW-1:0]     ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [AW-1:0]     DispReg;
  logic [DATA_W-1:0] DispData;
  logic              WB_Pending;

  int tests_run    = 0;
  int tests_failed = 0;

  // Architectural register contents as a program would see them.
  logic [DATA_W-1:0] arch [NREG];

  register_file dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .DispReg    (DispReg),
    .DispData   (DispData),
    .WB_Pending (WB_Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelRead(input logic [AW-1:0] a,
                                                  input logic we,
                                                  input logic [AW-1:0] wreg,
                                                  input logic [DATA_W-1:0] wdata);
    if (a == 0) return '0;
    if (we && wreg == a) return wdata;
    return arch[a];
  endfunction

  // One clock cycle: drive, check display mid-cycle, then check registered outputs.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wreg,
                               input logic [DATA_W-1:0] wdata,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                               input logic [AW-1:0] dreg);
    logic [DATA_W-1:0] exp1, exp2;
    logic              exp_pend;
    RegWrite  = we;
    WriteReg  = wreg;
    WriteData = wdata;
    ReadReg1  = r1;
    ReadReg2  = r2;
    DispReg   = dreg;
    #4;
    checkOutput("DispData", DispData, modelRead(dreg, we, wreg, wdata));
    exp1     = modelRead(r1, we, wreg, wdata);
    exp2     = modelRead(r2, we, wreg, wdata);
    exp_pend = we && (wreg != 0);
    if (exp_pend) arch[wreg] = wdata;
    @(posedge Clk);
    #1;
    checkOutput("ReadData1", ReadData1, exp1);
    checkOutput("ReadData2", ReadData2, exp2);
    checkOutput("WB_Pending", {7'b0, WB_Pending}, {7'b0, exp_pend});
  endtask

  task automatic clearModel();
    for (int i = 0; i < NREG; i++) arch[i] = '0;
  endtask

  initial begin
    clearModel();
    Clear     = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    DispReg   = 2'd1;
    #2;
    checkOutput("rst_ReadData1", ReadData1, 8'h00);
    checkOutput("rst_ReadData2", ReadData2, 8'h00);
    checkOutput("rst_WB_Pending", {7'b0, WB_Pending}, 8'h00);
    checkOutput("rst_DispData", DispData, 8'h00);
    #10;
    Clear = 1'b1;
    @(posedge Clk);
    #1;

    // Write r1, idle, read it back; pending flag must pulse for one cycle
    applyStimulus(1'b1, 2'd1, 8'h3C, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 2'd1);

    // Same-cycle forward of a live write
    applyStimulus(1'b1, 2'd2, 8'hA5, 2'd2, 2'd1, 2'd2);

    // Back-to-back writes to the same register
    applyStimulus(1'b1, 2'd3, 8'h11, 2'd3, 2'd3, 2'd3);
    applyStimulus(1'b1, 2'd3, 8'h22, 2'd3, 2'd2, 2'd3);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 2'd3);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 2'd3);

    // Writes to r0 are dropped
    applyStimulus(1'b1, 2'd0, 8'hFF, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 2'd0);

    // Operand pair for the ALU, then its result shown on the display at once
    applyStimulus(1'b1, 2'd1, 8'h7F, 2'd1, 2'd2, 2'd1);
    applyStimulus(1'b1, 2'd2, 8'h01, 2'd1, 2'd2, 2'd2);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 2'd0);
    applyStimulus(1'b1, 2'd3, 8'h80, 2'd1, 2'd2, 2'd3);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd3, 2'd3, 2'd3);

    // Reset while a write sits in the writeback stage
    applyStimulus(1'b1, 2'd2, 8'h5A, 2'd1, 2'd3, 2'd1);
    RegWrite = 1'b0;
    DispReg  = 2'd2;
    #1;
    Clear = 1'b0;
    #1;
    checkOutput("midrst_ReadData1", ReadData1, 8'h00);
    checkOutput("midrst_ReadData2", ReadData2, 8'h00);
    checkOutput("midrst_WB_Pending", {7'b0, WB_Pending}, 8'h00);
    checkOutput("midrst_DispData", DispData, 8'h00);
    clearModel();
    #2;
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd1, 2'd2);
    applyStimulus(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 2'd2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, NREG - 1)),
                    DATA_W'($urandom),
                    AW'($urandom_range(0, NREG - 1)),
                    AW'($urandom_range(0, NREG - 1)),
                    AW'($urandom_range(0, NREG - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
